// File: rtl/rv32i_regfile_ctrl.sv
// rv32i_regfile_ctrl
// Arbitrates the single rv32i_regfile port set between the core and a debug
// requester. After reset it sweeps zeros into x1..x(2**ADDR_W-1), then passes
// core traffic straight through. A debug request stalls the core for one
// register access and completes with a 4-phase req/ack handshake.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   core_wen/core_rd/core_din          core writeback port
//   core_rs1/core_rs2                  core read addresses
//   core_rsa/core_rsb                  core read data (rf_rsa/rf_rsb passthrough)
//   core_stall                         registered; core holds while high
//   dbg_req/dbg_we/dbg_addr/dbg_wdata  debug request (held until dbg_ack)
//   dbg_ack/dbg_rdata                  registered debug completion and read data
//   init_done                          registered; clear sweep finished
//   rf_wen/rf_rd/rf_din                regfile write port
//   rf_rs1/rf_rs2, rf_rsa/rf_rsb       regfile read addresses / read data
//
// state  | meaning
// INIT   | clear sweep, writes 0 to x[cnt], cnt = 1..2**ADDR_W-1
// RUN    | core owns the regfile ports
// ACCESS | one-cycle debug read/write, core stalled
// ACK    | dbg_ack high, waiting for dbg_req to drop
module rv32i_regfile_ctrl #(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 5,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_wen,
  input  logic [ADDR_W-1:0] core_rd,
  input  logic [XLEN-1:0]   core_din,
  input  logic [ADDR_W-1:0] core_rs1,
  input  logic [ADDR_W-1:0] core_rs2,
  output logic [XLEN-1:0]   core_rsa,
  output logic [XLEN-1:0]   core_rsb,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [XLEN-1:0]   dbg_wdata,
  output logic              dbg_ack,
  output logic [XLEN-1:0]   dbg_rdata,
  output logic              init_done,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_din,
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rs2,
  input  logic [XLEN-1:0]   rf_rsa,
  input  logic [XLEN-1:0]   rf_rsb
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_RUN    = 2'd1,
    S_ACCESS = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  localparam state_t            RST_STATE = (INIT_ZERO != 0) ? S_INIT : S_RUN;
  localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CNT_LAST  = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic              core_stall_q;
  logic              dbg_ack_q;
  logic              init_done_q;
  logic [XLEN-1:0]   dbg_rdata_q;
  logic              wen_raw;
  logic              dbg_start;

  assign dbg_start = dbg_req && init_done_q;

  always_comb begin
    state_d = state_q;
    wen_raw = 1'b0;
    rf_rd   = core_rd;
    rf_din  = core_din;
    rf_rs1  = core_rs1;
    rf_rs2  = core_rs2;
    unique case (state_q)
      S_INIT: begin
        wen_raw = 1'b1;
        rf_rd   = cnt_q;
        rf_din  = '0;
        if (cnt_q == CNT_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        // a core write in the same cycle as a debug request still completes
        wen_raw = core_wen && !core_stall_q;
        if (dbg_start) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        rf_rs1  = dbg_addr;
        rf_rd   = dbg_addr;
        wen_raw = dbg_we;
        rf_din  = dbg_wdata;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (!dbg_req) state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase
  end

  // x0 is hardwired zero: no source may ever write it
  assign rf_wen = wen_raw && (rf_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST_STATE;
      cnt_q        <= CNT_FIRST;
      core_stall_q <= (INIT_ZERO != 0);
      dbg_ack_q    <= 1'b0;
      dbg_rdata_q  <= '0;
      init_done_q  <= (INIT_ZERO == 0);
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_INIT: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q        <= CNT_FIRST;
            init_done_q  <= 1'b1;
            core_stall_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        S_RUN: begin
          if (dbg_start) core_stall_q <= 1'b1;
        end
        S_ACCESS: begin
          dbg_ack_q <= 1'b1;
          if (dbg_we)              dbg_rdata_q <= dbg_wdata;
          else if (dbg_addr == '0) dbg_rdata_q <= '0;
          else                     dbg_rdata_q <= rf_rsa;
        end
        S_ACK: begin
          if (!dbg_req) begin
            dbg_ack_q    <= 1'b0;
            core_stall_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_rsa   = rf_rsa;
  assign core_rsb   = rf_rsb;
  assign core_stall = core_stall_q;
  assign dbg_ack    = dbg_ack_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_rv32i_regfile_ctrl.sv
module tb_rv32i_regfile_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_wen = 1'b0;
  logic [4:0]  core_rd = '0;
  logic [31:0] core_din = '0;
  logic [4:0]  core_rs1 = '0;
  logic [4:0]  core_rs2 = '0;
  logic [31:0] core_rsa, core_rsb;
  logic        core_stall;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        init_done;
  logic        rf_wen;
  logic [4:0]  rf_rd, rf_rs1, rf_rs2;
  logic [31:0] rf_din, rf_rsa, rf_rsb;

  rv32i_regfile_ctrl #(.XLEN(32), .ADDR_W(5), .INIT_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_wen(core_wen), .core_rd(core_rd), .core_din(core_din),
    .core_rs1(core_rs1), .core_rs2(core_rs2),
    .core_rsa(core_rsa), .core_rsb(core_rsb), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .init_done(init_done),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_din(rf_din),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rsa(rf_rsa), .rf_rsb(rf_rsb)
  );

  always #5 clk = ~clk;

  // Regfile stand-in: combinational read, x0 holds garbage so the
  // controller's own x0 handling is exercised.
  logic [31:0] mem [32];
  logic        scramble = 1'b0;
  assign rf_rsa = mem[rf_rs1];
  assign rf_rsb = mem[rf_rs2];
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 32; i++) mem[i] <= $urandom | 32'h1;
    end else if (rf_wen) begin
      mem[rf_rd] <= rf_din;
    end
  end

  // Reference model: architectural register contents and expected debug results
  logic [31:0] ref_mem [32];
  logic [31:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each dbg_ack rise presents one debug result
  logic ack_seen = 1'b0;
  always @(negedge clk) begin
    if (dbg_ack && !ack_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dbg_ack_unexpected: got ack with rdata %h expected no ack", dbg_rdata);
      end else begin
        chk("dbg_rdata", dbg_rdata, exp_q.pop_front());
      end
    end
    ack_seen = dbg_ack;
    if (rst_n && rf_wen) chk("x0_never_written", {31'b0, rf_rd != 5'd0}, 32'd1);
  end

  task automatic do_reset(input bit early_req);
    dbg_req  = 1'b0;
    core_wen = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    scramble = 1'b1;
    @(negedge clk);
    scramble = 1'b0;
    chk("rst_init_done", {31'b0, init_done}, 32'd0);
    chk("rst_core_stall", {31'b0, core_stall}, 32'd1);
    chk("rst_dbg_ack", {31'b0, dbg_ack}, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      chk("sweep_wen", {31'b0, rf_wen}, 32'd1);
      chk("sweep_rd", {27'b0, rf_rd}, k);
      chk("sweep_din", rf_din, 32'd0);
      chk("sweep_init_done", {31'b0, init_done}, 32'd0);
      chk("sweep_stall", {31'b0, core_stall}, 32'd1);
      chk("sweep_no_ack", {31'b0, dbg_ack}, 32'd0);
      if (early_req && k == 4) begin
        exp_q.push_back(32'd0);
        dbg_we   = 1'b0;
        dbg_addr = 5'd9;
        dbg_req  = 1'b1;
      end
      @(negedge clk);
    end
    chk("sweep_done", {31'b0, init_done}, 32'd1);
    chk("sweep_unstall", {31'b0, core_stall}, 32'd0);
    for (int i = 1; i < 32; i++) chk("sweep_cleared", mem[i], 32'd0);
    if (early_req) begin
      @(negedge clk);
      chk("early_stall", {31'b0, core_stall}, 32'd1);
      chk("early_ack_lat1", {31'b0, dbg_ack}, 32'd0);
      @(negedge clk);
      chk("early_ack_lat2", {31'b0, dbg_ack}, 32'd1);
      dbg_req = 1'b0;
      @(negedge clk);
      chk("early_ack_drop", {31'b0, dbg_ack}, 32'd0);
      chk("early_unstall", {31'b0, core_stall}, 32'd0);
    end
  endtask

  // Debug access, optionally with a core write issued in the request cycle.
  // Called and returns at a negedge.
  task automatic dbg_op(input bit we, input logic [4:0] addr, input logic [31:0] wdata,
                        input bit cw, input logic [4:0] crd, input logic [31:0] cdin);
    if (cw && crd != 5'd0) ref_mem[crd] = cdin;
    exp_q.push_back(we ? wdata : ref_mem[addr]);
    if (we && addr != 5'd0) ref_mem[addr] = wdata;
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wdata;
    core_wen  = cw;
    core_rd   = crd;
    core_din  = cdin;
    @(negedge clk);
    chk("op_stall_t1", {31'b0, core_stall}, 32'd1);
    chk("op_ack_t1", {31'b0, dbg_ack}, 32'd0);
    // core_wen raised while stalled must be ignored
    core_wen = 1'b1;
    core_rd  = 5'($urandom_range(1, 31));
    core_din = $urandom;
    @(negedge clk);
    chk("op_ack_t2", {31'b0, dbg_ack}, 32'd1);
    chk("op_stall_t2", {31'b0, core_stall}, 32'd1);
    dbg_req = 1'b0;
    @(negedge clk);
    core_wen = 1'b0;
    chk("op_ack_drop", {31'b0, dbg_ack}, 32'd0);
    chk("op_unstall", {31'b0, core_stall}, 32'd0);
  endtask

  task automatic core_write(input logic [4:0] rd, input logic [31:0] din);
    core_wen = 1'b1;
    core_rd  = rd;
    core_din = din;
    if (rd != 5'd0) ref_mem[rd] = din;
    @(negedge clk);
    core_wen = 1'b0;
  endtask

  task automatic core_read(input logic [4:0] a, input logic [4:0] b);
    core_rs1 = a;
    core_rs2 = b;
    #1;
    chk("core_rsa", core_rsa, ref_mem[a]);
    chk("core_rsb", core_rsb, ref_mem[b]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  a;
    logic [31:0] d;
    do_reset(1'b0);

    dbg_op(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    dbg_op(1'b0, 5'd5, 32'd0, 1'b0, 5'd0, 32'd0);
    core_read(5'd5, 5'd6);

    dbg_op(1'b0, 5'd7, 32'd0, 1'b1, 5'd7, 32'h11);

    core_write(5'd0, 32'h12345678);
    dbg_op(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
    dbg_op(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    for (int n = 0; n < 60; n++) begin
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      case ($urandom_range(0, 3))
        0: core_write(a, d);
        1: core_read(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
        2: dbg_op(1'($urandom_range(0, 1)), a, d, 1'b0, 5'd0, 32'd0);
        default: dbg_op(1'b0, a, 32'd0, 1'b1, a, d);
      endcase
    end

    // Reset asserted while dbg_ack is high
    exp_q.push_back(32'hCAFEF00D);
    dbg_req   = 1'b1;
    dbg_we    = 1'b1;
    dbg_addr  = 5'd3;
    dbg_wdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    chk("abort_ack_high", {31'b0, dbg_ack}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ack_async", {31'b0, dbg_ack}, 32'd0);
    chk("abort_stall_async", {31'b0, core_stall}, 32'd1);
    chk("abort_init_done", {31'b0, init_done}, 32'd0);
    do_reset(1'b0);
    core_read(5'd3, 5'd5);

    do_reset(1'b1);
    dbg_op(1'b1, 5'd12, 32'h0BADF00D, 1'b0, 5'd0, 32'd0);
    dbg_op(1'b0, 5'd12, 32'd0, 1'b0, 5'd0, 32'd0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
